// File: rtl/apb_pkg.sv
// Shared types and width helpers for the APB requester and its address decoder.
package apb_pkg;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_SLVERR  = 2'b01,
        RSP_DECERR  = 2'b10,
        RSP_TIMEOUT = 2'b11
    } apb_rsp_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10,
        ST_RESP   = 2'b11
    } apb_state_e;

    // Completer index width; a single completer still gets one index bit.
    function automatic int idx_w_f(input int num_slv);
        return (num_slv > 32'sd2) ? $clog2(num_slv) : 32'sd1;
    endfunction

    function automatic int strb_w_f(input int data_w);
        return data_w / 32'sd8;
    endfunction

    // Wait counter width; kept at least one bit when the timeout is disabled.
    function automatic int cnt_w_f(input int timeout);
        return (timeout > 32'sd0) ? $clog2(timeout + 32'sd1) : 32'sd1;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational completer decode: index, one-hot select and decode error.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 16,
    parameter int SLV_AW  = 12,
    parameter int IDX_W   = idx_w_f(NUM_SLV)
) (
    input  logic [ADDR_W-1:0]  cmd_addr,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_SLV-1:0] sel,
    output logic               dec_err
);

    logic [ADDR_W-1:0]  upper_s;
    logic [NUM_SLV-1:0] hit_s;

    // An index past the last completer leaves hit_s empty, which flags the error.
    always_comb begin
        idx     = cmd_addr[SLV_AW +: IDX_W];
        upper_s = cmd_addr >> (SLV_AW + IDX_W);
        hit_s   = {NUM_SLV{1'b0}};
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx == IDX_W'(i)) begin
                hit_s[i] = 1'b1;
            end else begin
                hit_s[i] = 1'b0;
            end
        end
        dec_err = (|upper_s) | ~(|hit_s);
        if (dec_err) begin
            sel = {NUM_SLV{1'b0}};
        end else begin
            sel = hit_s;
        end
    end

endmodule

// File: rtl/apb_requester_chk.sv
// Protocol properties on the requester's APB select/enable outputs and decoder.
module apb_requester_chk #(
    parameter int NUM_SLV = 16,
    parameter int IDX_W   = 4
) (
    input logic               clk,
    input logic               rst_n,
    input logic [NUM_SLV-1:0] psel,
    input logic               penable,
    input logic [NUM_SLV-1:0] dec_sel,
    input logic [IDX_W-1:0]   dec_idx,
    input logic               dec_err
);

    a_psel_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown(psel) && $onehot0(psel));

    a_penable_psel: assert property (@(posedge clk) disable iff (!rst_n)
        penable |-> (|psel));

    a_penable_first: assert property (@(posedge clk) disable iff (!rst_n)
        $rose(|psel) |-> !penable);

    a_dec_sel: assert property (@(posedge clk) disable iff (!rst_n)
        !dec_err |-> (dec_sel == (NUM_SLV'(1) << dec_idx)));

endmodule

// File: rtl/apb_requester.sv
// APB4 requester: one outstanding command/response transfer with decode and timeout.
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 16,
    parameter int SLV_AW  = 12,
    parameter int TIMEOUT = 255
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_err,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [NUM_SLV-1:0]  PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    localparam int IDX_W  = idx_w_f(NUM_SLV);
    localparam int STRB_W = strb_w_f(DATA_W);
    localparam int CNT_W  = cnt_w_f(TIMEOUT);

    apb_state_e         state_r;
    apb_rsp_e           rsp_err_r;
    logic [NUM_SLV-1:0] psel_r;
    logic               penable_r;
    logic [ADDR_W-1:0]  paddr_r;
    logic               pwrite_r;
    logic [DATA_W-1:0]  pwdata_r;
    logic [STRB_W-1:0]  pstrb_r;
    logic               rsp_valid_r;
    logic [DATA_W-1:0]  rsp_rdata_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               timeout_hit_s;
    logic [IDX_W-1:0]   dec_idx_s;
    logic [NUM_SLV-1:0] dec_sel_s;
    logic               dec_err_s;

    apb_addr_decode #(
        .ADDR_W  (ADDR_W),
        .NUM_SLV (NUM_SLV),
        .SLV_AW  (SLV_AW),
        .IDX_W   (IDX_W)
    ) u_decode (
        .cmd_addr (cmd_addr),
        .idx      (dec_idx_s),
        .sel      (dec_sel_s),
        .dec_err  (dec_err_s)
    );

    apb_requester_chk #(
        .NUM_SLV (NUM_SLV),
        .IDX_W   (IDX_W)
    ) u_chk (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .psel    (psel_r),
        .penable (penable_r),
        .dec_sel (dec_sel_s),
        .dec_idx (dec_idx_s),
        .dec_err (dec_err_s)
    );

    // Saturating wait count and the abort condition for a hung completer.
    always_comb begin
        if (cnt_r != {CNT_W{1'b1}}) begin
            cnt_inc_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_inc_s = cnt_r;
        end
        timeout_hit_s = (TIMEOUT != 32'sd0) && (cnt_inc_s == CNT_W'(TIMEOUT));
    end

    // Transfer FSM with the command register and all registered outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r     <= ST_IDLE;
            psel_r      <= {NUM_SLV{1'b0}};
            penable_r   <= 1'b0;
            paddr_r     <= {ADDR_W{1'b0}};
            pwrite_r    <= 1'b0;
            pwdata_r    <= {DATA_W{1'b0}};
            pstrb_r     <= {STRB_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= RSP_OK;
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid && dec_err_s) begin
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= {DATA_W{1'b0}};
                        rsp_err_r   <= RSP_DECERR;
                    end else if (cmd_valid) begin
                        state_r  <= ST_SETUP;
                        psel_r   <= dec_sel_s;
                        paddr_r  <= cmd_addr;
                        pwrite_r <= cmd_write;
                        pwdata_r <= cmd_wdata;
                        pstrb_r  <= cmd_write ? cmd_strb : {STRB_W{1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    penable_r <= 1'b1;
                    state_r   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        state_r     <= ST_RESP;
                        psel_r      <= {NUM_SLV{1'b0}};
                        penable_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= pwrite_r ? {DATA_W{1'b0}} : PRDATA;
                        rsp_err_r   <= PSLVERR ? RSP_SLVERR : RSP_OK;
                    end else if (timeout_hit_s) begin
                        state_r     <= ST_RESP;
                        psel_r      <= {NUM_SLV{1'b0}};
                        penable_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= {DATA_W{1'b0}};
                        rsp_err_r   <= RSP_TIMEOUT;
                        cnt_r       <= cnt_inc_s;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    psel_r      <= {NUM_SLV{1'b0}};
                    penable_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = (state_r == ST_IDLE) && PRESETn;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign PADDR     = paddr_r;
    assign PSEL      = psel_r;
    assign PENABLE   = penable_r;
    assign PWRITE    = pwrite_r;
    assign PWDATA    = pwdata_r;
    assign PSTRB     = pstrb_r;

endmodule
